// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_seq
// Brief    : Multi-cycle adder for the 13-bit sign/4-bit exp/8-bit frac format.
//            Optional subtract port enabled by macro FP_ADD_SUB_EN.
// Revision : 1.0
// ============================================================================
module fp_add_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [12:0] a,
    input  logic [12:0] b,
`ifdef FP_ADD_SUB_EN
    input  logic        op,
`endif
    output logic        ready,
    output logic        done,
    output logic [12:0] result,
    output logic        ovf,
    output logic        ufl
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sx_q, sx_d;
    logic        sy_q, sy_d;
    logic [3:0]  ex_q, ex_d;
    logic [3:0]  diff_q, diff_d;
    logic [7:0]  fx_q, fx_d;
    logic [7:0]  fy_q, fy_d;
    logic        wovf_q, wovf_d;
    logic        wufl_q, wufl_d;
    logic [12:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        ufl_q, ufl_d;
    logic        done_q, done_d;

    logic        b_sign;
    logic        a_ge_b;
    logic [8:0]  sum;

`ifdef FP_ADD_SUB_EN
    assign b_sign = b[12] ^ op;
`else
    assign b_sign = b[12];
`endif

    // Magnitude compare ignores sign so the subtraction in ADD never goes negative.
    assign a_ge_b = (a[11:0] >= b[11:0]);
    assign sum    = (sx_q == sy_q) ? ({1'b0, fx_q} + {1'b0, fy_q})
                                   : ({1'b0, fx_q} - {1'b0, fy_q});

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        ex_d     = ex_q;
        diff_d   = diff_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        wovf_d   = wovf_q;
        wufl_d   = wufl_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ufl_d    = ufl_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (a_ge_b) begin
                        sx_d   = a[12];
                        ex_d   = a[11:8];
                        fx_d   = a[7:0];
                        sy_d   = b_sign;
                        fy_d   = b[7:0];
                        diff_d = a[11:8] - b[11:8];
                    end else begin
                        sx_d   = b_sign;
                        ex_d   = b[11:8];
                        fx_d   = b[7:0];
                        sy_d   = a[12];
                        fy_d   = a[7:0];
                        diff_d = b[11:8] - a[11:8];
                    end
                    wovf_d  = 1'b0;
                    wufl_d  = 1'b0;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if ((diff_q == 4'd0) || (fy_q == 8'd0)) begin
                    state_d = S_ADD;
                end else begin
                    fy_d   = fy_q >> 1;
                    diff_d = diff_q - 4'd1;
                end
            end
            S_ADD: begin
                if (sum[8]) begin
                    if (ex_q != 4'hF) begin
                        fx_d = sum[8:1];
                        ex_d = ex_q + 4'd1;
                    end else begin
                        fx_d   = 8'hFF;
                        ex_d   = 4'hF;
                        wovf_d = 1'b1;
                    end
                end else begin
                    fx_d = sum[7:0];
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (fx_q == 8'd0) begin
                    sx_d    = 1'b0;
                    ex_d    = 4'd0;
                    state_d = S_DONE;
                end else if (fx_q[7]) begin
                    state_d = S_DONE;
                end else if (ex_q == 4'd0) begin
                    sx_d    = 1'b0;
                    fx_d    = 8'd0;
                    wufl_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    fx_d = fx_q << 1;
                    ex_d = ex_q - 4'd1;
                end
            end
            S_DONE: begin
                result_d = {sx_q, ex_q, fx_q};
                ovf_d    = wovf_q;
                ufl_d    = wufl_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            ex_q     <= 4'd0;
            diff_q   <= 4'd0;
            fx_q     <= 8'd0;
            fy_q     <= 8'd0;
            wovf_q   <= 1'b0;
            wufl_q   <= 1'b0;
            result_q <= 13'd0;
            ovf_q    <= 1'b0;
            ufl_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            ex_q     <= ex_d;
            diff_q   <= diff_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            wovf_q   <= wovf_d;
            wufl_q   <= wufl_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ufl_q    <= ufl_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign ufl    = ufl_q;

endmodule
`default_nettype wire
